heartbeat_pacer: RTL
====================

# heartbeat_pacer

- Turns the 2-bit heartbeat code from the heartbeat model into a timed "lub-dub" beat pattern.
- Picks a beat period from the code and latches the code once per period, so rate changes take effect only at period boundaries.
- Sits between the heartbeat model and the beat indicator/LED output.
- Also provides a per-beat strobe and a wrapping beat counter for status readout.

## Interface
Parameters:
- PULSE_TICKS, 4: length of each of the lub and dub pulses, in ticks.
- GAP_TICKS, 6: gap between lub and dub, in ticks.
- PERIOD_0, 40: beat period in ticks for code 0 (excited/angry/nervous/stressed).
- PERIOD_1, 80: beat period in ticks for code 1 (happy/comfortable).
- PERIOD_2, 100: beat period in ticks for code 2 (bored/tired).
- PERIOD_3, 160: beat period in ticks for code 3 (asleep).
- Legal range: every PERIOD_x ≥ 2·PULSE_TICKS+GAP_TICKS+1 and ≤ 255; PULSE_TICKS and GAP_TICKS ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk time-base strobe; all pattern timing advances only on clk edges where tick=1.
- enable  in  1  run control; when 0 the pacer idles.
- heartbeat  in  2  heartbeat code; sampled only on entry to LUB.
- beat  out  1  high during LUB and DUB.
- lub  out  1  high during LUB only.
- beat_start  out  1  one-clk pulse on each LUB entry.
- rate  out  2  heartbeat code latched for the current period.
- beat_cnt  out  8  count of LUB entries, wraps 255→0.

## Operation
- FSM states: IDLE, LUB, GAP, DUB, REST.
- Registers:
  - phase_cnt (8 b): ticks spent in the current state.
  - per_cnt (8 b): ticks since LUB entry.
  - per_len: period selected from the latched code.
- IDLE → LUB on an edge with enable=1 and tick=1. On that edge:
  - rate ← heartbeat; per_len ← PERIOD_[heartbeat].
  - phase_cnt ← 0, per_cnt ← 0.
  - beat_start ← 1; beat_cnt ← beat_cnt+1.
- In LUB, GAP, DUB and REST, each tick increments per_cnt. Each tick also increments phase_cnt, except on transition ticks, where phase_cnt ← 0.
- Transition ticks:
  - LUB → GAP on the tick with phase_cnt = PULSE_TICKS−1.
  - GAP → DUB on the tick with phase_cnt = GAP_TICKS−1.
  - DUB → REST on the tick with phase_cnt = PULSE_TICKS−1.
  - REST → LUB on the tick with per_cnt = per_len−1, with the same actions as IDLE → LUB.
- Each period therefore lasts exactly per_len ticks.
- A code change mid-period is ignored until the next LUB entry.
- enable=0 in any non-IDLE state: next edge goes to IDLE with counters cleared and beat/lub/beat_start = 0. rate and beat_cnt hold. enable=0 takes priority over a simultaneous tick.
- Re-enabling always starts a fresh period at LUB.
- Outputs:
  - beat = (state==LUB) | (state==DUB); lub = (state==LUB). Both are registered with the state.
  - beat_start is registered and high for exactly one clk, independent of the tick spacing.
- Reset, asynchronous and any time including mid-pattern:
  - state = IDLE.
  - beat, lub, beat_start = 0; rate = 0; beat_cnt = 0; all counters = 0.

## Timing
- All outputs are registered and none depend combinationally on inputs.
- Start latency: beat, lub and beat_start go high on the first clk edge with enable=1, tick=1 and state=IDLE.
- LUB lasts PULSE_TICKS ticks. beat falls on the edge of the tick that ends it.
- Pattern offsets relative to LUB entry, in ticks:
  - lub/beat high over [0, P).
  - beat low over [P, P+G).
  - beat high over [P+G, 2P+G).
  - beat low over [2P+G, per_len).
- With tick held high, ticks equal clks.
- If reset is released with tick=1 and enable=1, the first edge after release may start LUB.

## Test plan
- Defaults, tick=1 constant, enable=1, heartbeat=1 → beat_start every 80 clks; within each period beat high clks 0–3 and 10–13, lub high clks 0–3; rate=1.
- heartbeat switched 1→0 at clk 20 of a period → that period still 80 clks, the following periods 40 clks; rate changes exactly at the next beat_start.
- tick every 4th clk, heartbeat=3 → lub high 16 clks, beat_start 1 clk wide, period 640 clks.
- enable dropped during DUB → beat=0 next edge, state IDLE, beat_cnt held; re-enable → fresh LUB on the first tick, beat_cnt+1.
- 257 periods at heartbeat=0 → beat_cnt reads 1 after wrap (255→0→1).
- reset asserted mid-LUB with no clk edge → beat, lub, beat_start, rate, beat_cnt all 0 immediately; after release, operation restarts from IDLE.

Source files
------------

// File: rtl/heartbeat_pacer.sv
// heartbeat_pacer: turns a 2-bit heartbeat code into a timed lub-dub beat pattern.
// The code is latched once per period on LUB entry; timing advances only on tick.
module heartbeat_pacer #(
    parameter int PULSE_TICKS = 4,
    parameter int GAP_TICKS   = 6,
    parameter int PERIOD_0    = 40,
    parameter int PERIOD_1    = 80,
    parameter int PERIOD_2    = 100,
    parameter int PERIOD_3    = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic [1:0] heartbeat,
    output logic       beat,
    output logic       lub,
    output logic       beat_start,
    output logic [1:0] rate,
    output logic [7:0] beat_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LUB  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DUB  = 3'd3;
    localparam logic [2:0] S_REST = 3'd4;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_TICKS - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] per_q, per_d;
    logic [7:0] per_len_q, per_len_d;
    logic [1:0] rate_q, rate_d;
    logic [7:0] cnt_q, cnt_d;
    logic       beat_q, beat_d;
    logic       lub_q, lub_d;
    logic       bstart_q, bstart_d;
    logic       start;

    function automatic logic [7:0] period_sel(input logic [1:0] code);
        case (code)
            2'd0:    period_sel = 8'(PERIOD_0);
            2'd1:    period_sel = 8'(PERIOD_1);
            2'd2:    period_sel = 8'(PERIOD_2);
            default: period_sel = 8'(PERIOD_3);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        per_d     = per_q;
        per_len_d = per_len_q;
        rate_d    = rate_q;
        cnt_d     = cnt_q;
        bstart_d  = 1'b0;
        start     = 1'b0;

        if (state_q == S_IDLE) begin
            start = enable & tick;
        end else if (!enable) begin
            // Disable wins over a coincident tick; rate and beat count are kept.
            state_d = S_IDLE;
            phase_d = '0;
            per_d   = '0;
        end else if (tick) begin
            phase_d = phase_q + 8'd1;
            per_d   = per_q + 8'd1;
            case (state_q)
                S_LUB: begin
                    if (phase_q == PULSE_LAST) begin
                        state_d = S_GAP;
                        phase_d = '0;
                    end
                end
                S_GAP: begin
                    if (phase_q == GAP_LAST) begin
                        state_d = S_DUB;
                        phase_d = '0;
                    end
                end
                S_DUB: begin
                    if (phase_q == PULSE_LAST) begin
                        state_d = S_REST;
                        phase_d = '0;
                    end
                end
                S_REST: begin
                    start = (per_q == per_len_q - 8'd1);
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    per_d   = '0;
                end
            endcase
        end

        if (start) begin
            state_d   = S_LUB;
            rate_d    = heartbeat;
            per_len_d = period_sel(heartbeat);
            phase_d   = '0;
            per_d     = '0;
            bstart_d  = 1'b1;
            cnt_d     = cnt_q + 8'd1;
        end

        // Outputs are decoded from the next state so they register alongside it.
        beat_d = (state_d == S_LUB) || (state_d == S_DUB);
        lub_d  = (state_d == S_LUB);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            per_q     <= '0;
            per_len_q <= '0;
            rate_q    <= '0;
            cnt_q     <= '0;
            beat_q    <= 1'b0;
            lub_q     <= 1'b0;
            bstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            per_q     <= per_d;
            per_len_q <= per_len_d;
            rate_q    <= rate_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            lub_q     <= lub_d;
            bstart_q  <= bstart_d;
        end
    end

    assign beat       = beat_q;
    assign lub        = lub_q;
    assign beat_start = bstart_q;
    assign rate       = rate_q;
    assign beat_cnt   = cnt_q;

endmodule
